// File: rtl/sr_latch_driver.sv
// Sequencer that turns word-write/clear requests into S/R/gate/clear pulses for a bank of gated SR latches.
// Define SR_LATCH_DRIVER_READBACK_EN to build the Q readback check with retry and err reporting.
module sr_latch_driver #(
  parameter int WIDTH      = 8,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic             C,
  input  logic             nR,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_clr,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  output logic             lat_C,
  output logic [WIDTH-1:0] lat_S,
  output logic [WIDTH-1:0] lat_R,
  output logic             lat_nP,
  output logic             lat_nR,
  input  logic [WIDTH-1:0] lat_Q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // DRIVE  | gate open with S/R from captured data and mask
  // CLEAR  | latch clear held active
  // SETTLE | all latch controls inactive while Q settles
  // CHECK  | compare Q with the expected word (readback build only)
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CLEAR,
    SETTLE,
`ifdef SR_LATCH_DRIVER_READBACK_EN
    CHECK,
`endif
    DONE
  } state_t;

  localparam int CYC_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(CYC_MAX + 1);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cyc_q, cyc_nxt;
  logic             clr_q, clr_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [WIDTH-1:0] mask_q, mask_nxt;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0]    retry_q, retry_nxt;
  logic             err_q, err_nxt;
  logic [WIDTH-1:0] mismatch;

  assign mismatch = clr_q ? lat_Q : ((lat_Q ^ data_q) & mask_q);
  assign err      = err_q;
`else
  logic unused_readback;
  assign unused_readback = ^{lat_Q, MAX_RETRY[0]};
  assign err             = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign lat_nP    = 1'b1;

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_q;
    clr_nxt   = clr_q;
    data_nxt  = data_q;
    mask_nxt  = mask_q;
`ifdef SR_LATCH_DRIVER_READBACK_EN
    retry_nxt = retry_q;
    err_nxt   = err_q;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          clr_nxt   = req_clr;
          data_nxt  = req_data;
          mask_nxt  = req_mask;
          cyc_nxt   = PULSE_LD;
          state_nxt = req_clr ? CLEAR : DRIVE;
`ifdef SR_LATCH_DRIVER_READBACK_EN
          err_nxt   = 1'b0;
`endif
        end
      end
      DRIVE, CLEAR: begin
        if (cyc_q == '0) begin
          cyc_nxt   = SETTLE_LD;
          state_nxt = SETTLE;
        end else begin
          cyc_nxt = cyc_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cyc_q == '0) begin
`ifdef SR_LATCH_DRIVER_READBACK_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          cyc_nxt = cyc_q - 1'b1;
        end
      end
`ifdef SR_LATCH_DRIVER_READBACK_EN
      CHECK: begin
        if (mismatch == '0) begin
          err_nxt   = 1'b0;
          state_nxt = DONE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_nxt = retry_q + 1'b1;
          cyc_nxt   = PULSE_LD;
          state_nxt = clr_q ? CLEAR : DRIVE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        state_nxt = IDLE;
`ifdef SR_LATCH_DRIVER_READBACK_EN
        retry_nxt = '0;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch controls are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state  <= IDLE;
      cyc_q  <= '0;
      clr_q  <= 1'b0;
      data_q <= '0;
      mask_q <= '0;
      lat_C  <= 1'b0;
      lat_S  <= '0;
      lat_R  <= '0;
      lat_nR <= 1'b1;
`ifdef SR_LATCH_DRIVER_READBACK_EN
      retry_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cyc_q  <= cyc_nxt;
      clr_q  <= clr_nxt;
      data_q <= data_nxt;
      mask_q <= mask_nxt;
      lat_C  <= (state_nxt == DRIVE);
      lat_S  <= (state_nxt == DRIVE) ? (data_nxt & mask_nxt) : '0;
      lat_R  <= (state_nxt == DRIVE) ? (~data_nxt & mask_nxt) : '0;
      lat_nR <= (state_nxt != CLEAR);
`ifdef SR_LATCH_DRIVER_READBACK_EN
      retry_q <= retry_nxt;
      err_q   <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: latch bank model, vector table, reset corner cases and random requests vs a reference model.
// Expectations follow the SR_LATCH_DRIVER_READBACK_EN setting used for the build.
module tb_sr_latch_driver;
  localparam int W  = 8;
  localparam int P  = 2;
  localparam int S  = 1;
  localparam int MR = 2;
`ifdef SR_LATCH_DRIVER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int D1 = RB ? 5 : 4;
  localparam int DS = RB ? 13 : 4;

  logic         C = 1'b0;
  logic         nR = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_clr = 1'b0;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] req_mask = '0;
  logic         lat_C;
  logic [W-1:0] lat_S, lat_R;
  logic         lat_nP, lat_nR;
  logic [W-1:0] lat_Q;
  logic         busy, done, err;

  sr_latch_driver #(.WIDTH(W), .PULSE_CYC(P), .SETTLE_CYC(S), .MAX_RETRY(MR)) dut (
    .C(C), .nR(nR), .req_valid(req_valid), .req_ready(req_ready), .req_clr(req_clr),
    .req_data(req_data), .req_mask(req_mask), .lat_C(lat_C), .lat_S(lat_S), .lat_R(lat_R),
    .lat_nP(lat_nP), .lat_nR(lat_nR), .lat_Q(lat_Q), .busy(busy), .done(done), .err(err)
  );

  always #5 C = ~C;

  // External latch bank; stuck marks bits whose Q output is stuck at 0.
  logic [W-1:0] lq_int = '0;
  logic [W-1:0] stuck  = '0;
  assign lat_Q = lq_int & ~stuck;

  always begin
    @(posedge C);
    #2;
    if (!lat_nR) lq_int = '0;
    else if (lat_C) lq_int = (lq_int | lat_S) & ~lat_R;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         clr;
    logic [W-1:0] data;
    logic [W-1:0] mask;
    logic [W-1:0] stk;
    logic [W-1:0] exp_s;
    logic [W-1:0] exp_r;
    logic [W-1:0] exp_q;
    logic         exp_err;
    int           exp_done;
    int           exp_cp;
    int           exp_np;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int           done_cyc = -1;
    int           cp = 0;
    int           np = 0;
    int           viol = 0;
    logic [W-1:0] s_seen = '0;
    logic [W-1:0] r_seen = '0;
    logic         err_seen = 1'b0;
    stuck = v.stk;
    @(negedge C);
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_clr   = v.clr;
    req_data  = v.data;
    req_mask  = v.mask;
    @(posedge C);
    #1;
    // keep requesting with junk while busy: must be ignored
    req_clr  = 1'($urandom);
    req_data = W'($urandom);
    req_mask = W'($urandom);
    for (int n = 1; n <= 200; n++) begin
      @(negedge C);
      if (lat_C) begin
        cp++;
        s_seen = lat_S;
        r_seen = lat_R;
      end
      if (!lat_nR) np++;
      if ((lat_S & lat_R) != '0 || lat_nP !== 1'b1 || (lat_C && !lat_nR) || busy !== 1'b1 || req_ready !== 1'b0)
        viol++;
      if (done) begin
        done_cyc = n;
        err_seen = err;
        break;
      end
    end
    req_valid = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, v.exp_done);
    chk({tag, "_err"}, err_seen, v.exp_err);
    chk({tag, "_gate_cycles"}, cp, v.exp_cp);
    chk({tag, "_clear_cycles"}, np, v.exp_np);
    chk({tag, "_lat_S"}, s_seen, v.exp_s);
    chk({tag, "_lat_R"}, r_seen, v.exp_r);
    chk({tag, "_invariants"}, viol, 0);
    chk({tag, "_Q"}, lat_Q, v.exp_q);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t         vt[5];
  vec_t         rv;
  logic [W-1:0] ref_int;
  logic [W-1:0] obs, mism;
  int           att;

  initial begin
    vt[0] = '{1'b0, 8'hA5, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'hA5, 1'b0, D1, P, 0};
    vt[1] = '{1'b0, 8'h0F, 8'h3C, 8'h00, 8'h0C, 8'h30, 8'h8D, 1'b0, D1, P, 0};
    vt[2] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, D1, P, 0};
    vt[3] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, D1, 0, P};
    vt[4] = '{1'b0, 8'h08, 8'hFF, 8'h08, 8'h08, 8'hF7, 8'h00, (RB == 1), DS, (RB ? 3 * P : P), 0};

    // Reset held with a pending request
    req_valid = 1'b1;
    req_data  = 8'hFF;
    req_mask  = 8'hFF;
    repeat (3) @(posedge C);
    @(negedge C);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_lat_C", lat_C, 0);
    chk("rst_lat_S", lat_S, 0);
    chk("rst_lat_R", lat_R, 0);
    chk("rst_lat_nP", lat_nP, 1);
    chk("rst_lat_nR", lat_nR, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    req_valid = 1'b0;
    nR = 1'b1;
    @(negedge C);
    chk("rst_no_accept", busy, 0);

    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));
    stuck = '0;

    // Reset asserted in the middle of DRIVE
    @(negedge C);
    req_valid = 1'b1;
    req_clr   = 1'b0;
    req_data  = 8'h3C;
    req_mask  = 8'hFF;
    @(posedge C);
    #1;
    req_valid = 1'b0;
    @(negedge C);
    chk("mid_gate_before", lat_C, 1);
    #1;
    nR = 1'b0;
    #1;
    chk("mid_lat_C", lat_C, 0);
    chk("mid_lat_S", lat_S, 0);
    chk("mid_lat_R", lat_R, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 1);
    @(negedge C);
    nR = 1'b1;
    rv = '{1'b0, 8'hA5, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'hA5, 1'b0, D1, P, 0};
    run_vec(rv, "after_rst");
    ref_int = 8'hA5;

    // Random requests against a reference of latch contents and retry outcome
    for (int k = 0; k < 40; k++) begin
      rv.clr  = ($urandom_range(5) == 0);
      rv.data = W'($urandom);
      rv.mask = W'($urandom);
      rv.stk  = ($urandom_range(3) == 0) ? W'(1 << $urandom_range(W - 1)) : '0;
      ref_int = rv.clr ? '0 : ((ref_int & ~rv.mask) | (rv.data & rv.mask));
      obs     = ref_int & ~rv.stk;
      mism    = rv.clr ? obs : ((obs ^ rv.data) & rv.mask);
      att     = (RB == 1 && mism != '0) ? MR + 1 : 1;
      rv.exp_s    = rv.clr ? '0 : (rv.data & rv.mask);
      rv.exp_r    = rv.clr ? '0 : (~rv.data & rv.mask);
      rv.exp_q    = obs;
      rv.exp_err  = (RB == 1 && mism != '0);
      rv.exp_done = att * (P + S + 1) + RB;
      rv.exp_cp   = rv.clr ? 0 : att * P;
      rv.exp_np   = rv.clr ? att * P : 0;
      run_vec(rv, $sformatf("rnd%0d", k));
    end
    stuck = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
